// File: rtl/matrix_scan_sequencer.sv
// Row-major row/column scan sequencer for the bolometer mux matrix.
// Each pixel is selected, left to settle for SettleCycles clocks, then one
// ADC conversion is requested; the scan moves on only after the ADC reports
// completion. Frames can run one-shot or back to back, and a stop request
// finishes the pixel being processed before returning to idle.
module matrix_scan_sequencer #(
  parameter int ROWS         = 2,
  parameter int COLS         = 2,
  parameter int RowWidth     = 5,
  parameter int ColWidth     = 5,
  parameter int SettleCycles = 16,
  parameter int SetWidth     = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                cont_i,
  input  logic                stop_i,
  input  logic                adc_done_i,
  output logic [RowWidth-1:0] row_o,
  output logic [ColWidth-1:0] col_o,
  output logic                sel_valid_o,
  output logic                sample_o,
  output logic                busy_o,
  output logic                frame_done_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_e;

  localparam logic [RowWidth-1:0] RowLast = RowWidth'(ROWS - 1);
  localparam logic [ColWidth-1:0] ColLast = ColWidth'(COLS - 1);
  localparam logic [SetWidth-1:0] SetLast = SetWidth'(SettleCycles - 1);

  state_e              state_q, state_d;
  logic [RowWidth-1:0] row_q;
  logic [ColWidth-1:0] col_q;
  logic [SetWidth-1:0] cnt_q;
  logic                stop_pend_q;
  logic                sample_q;
  logic                frame_done_q;

  // A stop arriving together with the ADC completion still counts.
  logic adc_acc;
  logic last_pix;
  logic stop_now;
  logic row_wrap;

  assign adc_acc  = (state_q == ST_SAMPLE) && adc_done_i;
  assign last_pix = (row_q == RowLast) && (col_q == ColLast);
  assign stop_now = stop_pend_q | stop_i;
  assign row_wrap = (col_q == ColLast);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode: settle dwell, ADC wait and end-of-pixel decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SetLast) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (adc_done_i) begin
          if (last_pix)      state_d = (cont_i && !stop_now) ? ST_SETTLE : ST_IDLE;
          else if (stop_now) state_d = ST_IDLE;
          else               state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded straight from the state.
  always_comb begin
    busy_o      = 1'b0;
    sel_valid_o = 1'b0;
    case (state_q)
      ST_SETTLE, ST_SAMPLE: begin
        busy_o      = 1'b1;
        sel_valid_o = 1'b1;
      end
      default: begin
        busy_o      = 1'b0;
        sel_valid_o = 1'b0;
      end
    endcase
  end

  // Settle counter: restarts on every entry into SETTLE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                                          cnt_q <= '0;
    else if (state_q == ST_SETTLE && state_d == ST_SETTLE) cnt_q <= cnt_q + SetWidth'(1);
    else                                                  cnt_q <= '0;
  end

  // Pixel address: cleared on start or frame wrap, advanced on ADC completion.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else if (state_q == ST_IDLE && start_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (adc_acc) begin
      if (last_pix) begin
        // Back-to-back frame restarts at the origin; otherwise the last
        // pixel stays selected until the next start.
        if (state_d == ST_SETTLE) begin
          row_q <= '0;
          col_q <= '0;
        end
      end else if (!stop_now) begin
        if (row_wrap) begin
          col_q <= '0;
          row_q <= row_q + RowWidth'(1);
        end else begin
          col_q <= col_q + ColWidth'(1);
        end
      end
    end
  end

  // Stop request latch: armed by stop_i while busy, dropped when idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                  stop_pend_q <= 1'b0;
    else if (state_d == ST_IDLE)  stop_pend_q <= 1'b0;
    else if (busy_o && stop_i)    stop_pend_q <= 1'b1;
  end

  // Registered pulses: ADC start on SAMPLE entry, frame done after last pixel.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sample_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sample_q     <= (state_q == ST_SETTLE) && (state_d == ST_SAMPLE);
      frame_done_q <= adc_acc && last_pix;
    end
  end

  assign row_o        = row_q;
  assign col_o        = col_q;
  assign sample_o     = sample_q;
  assign frame_done_o = frame_done_q;

endmodule
